// File: rtl/sha256_host_pkg.sv
// sha256_host_pkg -- shared types and constants for the SHA-256 GPIO host.
//   host_state_e : controller state (IDLE, SEND, COLLECT)
//   DIGEST_BYTES : number of digest bytes returned by the engine
//   DIGEST_W     : digest width in bits
package sha256_host_pkg;

    localparam int DIGEST_BYTES = 32;
    localparam int DIGEST_W     = 256;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SEND    = 2'd1,
        ST_COLLECT = 2'd2
    } host_state_e;

endpackage

// File: rtl/sha256_gpio_host.sv
// sha256_gpio_host -- streams a message into a GPIO-attached SHA-256 engine
// and collects the 32-byte digest it returns.
//
// Parameters
//   TIMEOUT_CYCLES : cycles allowed in COLLECT before the transaction aborts
//   LEN_W          : width of the saturating sent-byte counter
// Ports
//   clk, rst                 : clock, synchronous active-high reset
//   start                    : one-cycle request, honoured only in IDLE
//   s_data/s_valid/s_last    : upstream message bytes; s_ready back-pressure
//   gpio_din/valid/last      : bytes to the engine; gpio_ready engine accept
//   gpio_busy                : engine status, informational only
//   gpio_dout/gpio_dvalid    : digest bytes from the engine, MSB byte first
//   digest, digest_valid     : captured digest and one-cycle completion pulse
//   busy, timeout_err        : transaction in flight; one-cycle abort pulse
//   bytes_sent               : bytes accepted by the engine this transaction
//   state_dbg                : current controller state
// Optional feature (macro SHA256_HOST_CMP_EN)
//   exp_digest, match        : registered compare of digest against exp_digest
//
// Handshake: a byte moves upstream->engine on a rising edge where the host is
// in SEND and s_valid && gpio_ready; s_ready mirrors gpio_ready in SEND and is
// 0 elsewhere. The digest side has no back-pressure: each gpio_dvalid cycle in
// COLLECT delivers exactly one byte.
module sha256_gpio_host
    import sha256_host_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int LEN_W          = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [7:0]          s_data,
    input  logic                s_valid,
    input  logic                s_last,
    output logic                s_ready,
    output logic [7:0]          gpio_din,
    output logic                gpio_valid,
    output logic                gpio_last,
    input  logic                gpio_ready,
    input  logic                gpio_busy,
    input  logic [7:0]          gpio_dout,
    input  logic                gpio_dvalid,
    output logic [DIGEST_W-1:0] digest,
    output logic                digest_valid,
    output logic                busy,
    output logic                timeout_err,
    output logic [LEN_W-1:0]    bytes_sent,
`ifdef SHA256_HOST_CMP_EN
    input  logic [DIGEST_W-1:0] exp_digest,
    output logic                match,
`endif
    output host_state_e         state_dbg
);

    localparam int              TMO_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [4:0]      IDX_LAST = 5'(DIGEST_BYTES - 1);

    host_state_e          state_q, state_d;
    logic [4:0]           byte_idx_q;
    logic [TMO_W-1:0]     tmo_q;
    logic [DIGEST_W-1:0]  digest_q;
    logic [LEN_W-1:0]     bytes_q;
    logic                 dv_q;
    logic                 to_q;
    logic                 xfer;
    logic                 dig_done;
    logic                 tmo_hit;
    logic                 unused_busy;

    // Engine busy is status only; nothing in the controller depends on it.
    assign unused_busy = gpio_busy;

    always_comb begin
        state_d  = state_q;
        xfer     = 1'b0;
        dig_done = 1'b0;
        tmo_hit  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) state_d = ST_SEND;
            end
            ST_SEND: begin
                xfer = s_valid && gpio_ready;
                if (xfer && s_last) state_d = ST_COLLECT;
            end
            ST_COLLECT: begin
                dig_done = gpio_dvalid && (byte_idx_q == IDX_LAST);
                // The final digest byte wins if it lands on the timeout cycle.
                tmo_hit  = !dig_done && (tmo_q == TMO_LAST);
                if (dig_done || tmo_hit) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            byte_idx_q <= '0;
            tmo_q      <= '0;
            digest_q   <= '0;
            bytes_q    <= '0;
            dv_q       <= 1'b0;
            to_q       <= 1'b0;
        end else begin
            state_q <= state_d;
            dv_q    <= 1'b0;
            to_q    <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) bytes_q <= '0;
                end
                ST_SEND: begin
                    if (xfer && (bytes_q != {LEN_W{1'b1}})) bytes_q <= bytes_q + LEN_W'(1);
                    if (xfer && s_last) begin
                        byte_idx_q <= '0;
                        tmo_q      <= '0;
                    end
                end
                ST_COLLECT: begin
                    tmo_q <= tmo_q + TMO_W'(1);
                    if (gpio_dvalid) begin
                        digest_q   <= {digest_q[DIGEST_W-9:0], gpio_dout};
                        byte_idx_q <= byte_idx_q + 5'd1;
                    end
                    if (dig_done) dv_q <= 1'b1;
                    if (tmo_hit)  to_q <= 1'b1;
                end
                default: ;
            endcase
        end
    end

`ifdef SHA256_HOST_CMP_EN
    logic match_q;

    // Compares the value the digest register takes on the completing edge,
    // so match becomes valid together with digest_valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            match_q <= 1'b0;
        end else if (state_q == ST_IDLE && start) begin
            match_q <= 1'b0;
        end else if (dig_done) begin
            match_q <= ({digest_q[DIGEST_W-9:0], gpio_dout} == exp_digest);
        end
    end

    assign match = match_q;
`endif

    assign s_ready      = (state_q == ST_SEND) && gpio_ready;
    assign gpio_valid   = (state_q == ST_SEND) && s_valid;
    assign gpio_din     = s_data;
    assign gpio_last    = s_last;
    assign digest       = digest_q;
    assign digest_valid = dv_q;
    assign timeout_err  = to_q;
    assign busy         = (state_q != ST_IDLE);
    assign bytes_sent   = bytes_q;
    assign state_dbg    = state_q;

endmodule

// File: tb/tb_sha256_gpio_host.sv
// tb_sha256_gpio_host -- directed bench for sha256_gpio_host.
// Main instance uses LEN_W=4 (so saturation is reachable) and the default
// timeout; a second instance with TIMEOUT_CYCLES=16 shares the inputs and is
// only examined in the timeout scenario.
module tb_sha256_gpio_host;
    import sha256_host_pkg::*;

    localparam int LW       = 4;
    localparam int TO_MAIN  = 1024;
    localparam int TO_SHORT = 16;
    localparam int SAT      = (1 << LW) - 1;
    localparam logic [255:0] ABC_D =
        256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
    localparam logic [255:0] ONE_D =
        256'hca978112ca1bbdcafac231b39a23dc4da786eff8147c4e72b9807785afee48bb;

    // ---------------- clock / reset / stimulus signals ----------------
    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [7:0]   s_data = 8'h00;
    logic         s_valid = 1'b0;
    logic         s_last = 1'b0;
    logic         gpio_ready = 1'b1;
    logic         gpio_busy = 1'b0;
    logic [7:0]   gpio_dout = 8'h00;
    logic         gpio_dvalid = 1'b0;
    logic [255:0] exp_digest = ABC_D;

    always #5 clk = ~clk;

    // main DUT outputs
    logic         s_ready, gpio_valid, gpio_last, digest_valid, busy, timeout_err;
    logic [7:0]   gpio_din;
    logic [255:0] digest;
    logic [LW-1:0] bytes_sent;
    host_state_e  state_dbg;
    logic         match;
    // short-timeout DUT outputs
    logic         t_s_ready, t_gpio_valid, t_gpio_last, t_digest_valid, t_busy, t_timeout_err;
    logic [7:0]   t_gpio_din;
    logic [255:0] t_digest;
    logic [LW-1:0] t_bytes_sent;
    host_state_e  t_state_dbg;
    logic         t_match;

    sha256_gpio_host #(.TIMEOUT_CYCLES(TO_MAIN), .LEN_W(LW)) dut (
        .clk(clk), .rst(rst), .start(start),
        .s_data(s_data), .s_valid(s_valid), .s_last(s_last), .s_ready(s_ready),
        .gpio_din(gpio_din), .gpio_valid(gpio_valid), .gpio_last(gpio_last),
        .gpio_ready(gpio_ready), .gpio_busy(gpio_busy),
        .gpio_dout(gpio_dout), .gpio_dvalid(gpio_dvalid),
        .digest(digest), .digest_valid(digest_valid),
        .busy(busy), .timeout_err(timeout_err), .bytes_sent(bytes_sent),
`ifdef SHA256_HOST_CMP_EN
        .exp_digest(exp_digest), .match(match),
`endif
        .state_dbg(state_dbg)
    );

    sha256_gpio_host #(.TIMEOUT_CYCLES(TO_SHORT), .LEN_W(LW)) dut_to (
        .clk(clk), .rst(rst), .start(start),
        .s_data(s_data), .s_valid(s_valid), .s_last(s_last), .s_ready(t_s_ready),
        .gpio_din(t_gpio_din), .gpio_valid(t_gpio_valid), .gpio_last(t_gpio_last),
        .gpio_ready(gpio_ready), .gpio_busy(gpio_busy),
        .gpio_dout(gpio_dout), .gpio_dvalid(gpio_dvalid),
        .digest(t_digest), .digest_valid(t_digest_valid),
        .busy(t_busy), .timeout_err(t_timeout_err), .bytes_sent(t_bytes_sent),
`ifdef SHA256_HOST_CMP_EN
        .exp_digest(exp_digest), .match(t_match),
`endif
        .state_dbg(t_state_dbg)
    );

`ifndef SHA256_HOST_CMP_EN
    assign match   = 1'b0;
    assign t_match = 1'b0;
`endif

    // ---------------- checking helpers ----------------
    int tests = 0;
    int fails = 0;

    task automatic chk_b(input string name, input logic act, input logic exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_n(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_d(input string name, input logic [255:0] act, input logic [255:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %064h expected %064h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    // phase: 0 idle, 1 sending message, 2 awaiting digest bytes
    int           ph = 0;
    int           m_sent = 0;
    int           m_got = 0;
    int           m_age = 0;
    logic [255:0] m_digest = '0;
    logic         m_dv = 1'b0;
    logic         m_to = 1'b0;
    logic         m_match = 1'b0;

    always @(posedge clk) begin
        m_dv <= 1'b0;
        m_to <= 1'b0;
        if (rst) begin
            ph <= 0; m_sent <= 0; m_got <= 0; m_age <= 0;
            m_digest <= '0; m_match <= 1'b0;
        end else if (ph == 0) begin
            if (start) begin
                ph <= 1; m_sent <= 0; m_match <= 1'b0;
            end
        end else if (ph == 1) begin
            if (s_valid && gpio_ready) begin
                m_sent <= m_sent + 1;
                if (s_last) begin
                    ph <= 2; m_got <= 0; m_age <= 0;
                end
            end
        end else begin
            m_age <= m_age + 1;
            if (gpio_dvalid) begin
                m_digest <= {m_digest[247:0], gpio_dout};
                m_got    <= m_got + 1;
            end
            if (gpio_dvalid && m_got == 31) begin
                ph <= 0; m_dv <= 1'b1;
                m_match <= ({m_digest[247:0], gpio_dout} == exp_digest);
            end else if (m_age + 1 == TO_MAIN) begin
                ph <= 0; m_to <= 1'b1;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    logic armed = 1'b0;
    int   dv_cnt = 0;
    int   t_dv_cnt = 0;

    always @(negedge clk) begin
        if (digest_valid)   dv_cnt   <= dv_cnt + 1;
        if (t_digest_valid) t_dv_cnt <= t_dv_cnt + 1;
        if (armed) begin
            chk_b("busy", busy, ph != 0);
            chk_b("digest_valid", digest_valid, m_dv);
            chk_b("timeout_err", timeout_err, m_to);
            chk_d("digest", digest, m_digest);
            chk_n("bytes_sent", int'(bytes_sent), (m_sent > SAT) ? SAT : m_sent);
            chk_b("gpio_valid", gpio_valid, (ph == 1) && s_valid);
            chk_b("s_ready", s_ready, (ph == 1) && gpio_ready);
            if (ph == 1) begin
                chk_n("gpio_din", int'(gpio_din), int'(s_data));
                chk_b("gpio_last", gpio_last, s_last);
            end
`ifdef SHA256_HOST_CMP_EN
            chk_b("match", match, m_match);
`endif
        end
    end

    // ---------------- driver tasks ----------------
    logic [7:0] msg_buf [32];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Sends msg_buf[0..n-1]; if stall_idx >= 0 the engine holds gpio_ready low
    // for stall_len cycles while that byte is offered, and a stray start is
    // raised during the stall.
    task automatic send_msg(input int n, input int stall_idx, input int stall_len);
        for (int i = 0; i < n; i++) begin
            s_data  = msg_buf[i];
            s_last  = (i == n - 1);
            s_valid = 1'b1;
            if (i == stall_idx) begin
                gpio_ready = 1'b0;
                start = 1'b1;
                tick();
                start = 1'b0;
                for (int k = 1; k < stall_len; k++) tick();
                gpio_ready = 1'b1;
            end
            tick();
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic engine_reply(input logic [255:0] d, input int nbytes);
        gpio_busy = 1'b1;
        for (int i = 0; i < nbytes; i++) begin
            gpio_dout   = d[255 - 8*i -: 8];
            gpio_dvalid = 1'b1;
            tick();
            gpio_dvalid = 1'b0;
            if (i % 3 == 0) tick();
        end
        gpio_busy = 1'b0;
    endtask

    task automatic load_abc();
        msg_buf[0] = 8'h61; msg_buf[1] = 8'h62; msg_buf[2] = 8'h63;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    // One complete transaction with literal post-conditions.
    task automatic run_txn(input string tag, input int n, input int stall_idx,
                           input logic [255:0] d, input int exp_bytes);
        int dv0;
        dv0 = dv_cnt;
        do_start();
        send_msg(n, stall_idx, 5);
        tick(); tick();
        engine_reply(d, 32);
        chk_b({tag, "_dv"}, digest_valid, 1'b1);
        chk_d({tag, "_digest"}, digest, d);
        chk_n({tag, "_bytes"}, int'(bytes_sent), exp_bytes);
        chk_b({tag, "_busy"}, busy, 1'b0);
        repeat (3) tick();
        chk_n({tag, "_dv_pulses"}, dv_cnt - dv0, 1);
        chk_d({tag, "_held"}, digest, d);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int first_to;
        int dv0;
        int tdv0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        armed = 1'b1;

        // reset values
        chk_b("rst_busy", busy, 1'b0);
        chk_d("rst_digest", digest, 256'h0);
        chk_n("rst_bytes", int'(bytes_sent), 0);
        chk_b("rst_dv", digest_valid, 1'b0);
        chk_b("rst_to", timeout_err, 1'b0);
        chk_b("rst_match", match, 1'b0);

        // "abc"
        load_abc();
        run_txn("abc", 3, -1, ABC_D, 3);

        // digest bytes while idle are ignored
        gpio_dout = 8'hff; gpio_dvalid = 1'b1;
        repeat (3) tick();
        gpio_dvalid = 1'b0;
        chk_d("idle_dvalid", digest, ABC_D);

        // single byte "a"
        msg_buf[0] = 8'h61;
        run_txn("one", 1, -1, ONE_D, 1);

        // "abc" with a 5-cycle ready stall before byte 2
        load_abc();
        run_txn("stall", 3, 1, ABC_D, 3);

        // 20-byte message saturates the 4-bit counter
        for (int i = 0; i < 20; i++) msg_buf[i] = 8'(i + 1);
        run_txn("sat", 20, -1, ONE_D, SAT);

        // reset after 10 of 32 digest bytes
        dv0 = dv_cnt;
        load_abc();
        do_start();
        send_msg(3, -1, 0);
        engine_reply(ABC_D, 10);
        do_reset();
        chk_b("mid_rst_busy", busy, 1'b0);
        chk_d("mid_rst_digest", digest, 256'h0);
        chk_n("mid_rst_bytes", int'(bytes_sent), 0);
        chk_n("mid_rst_no_dv", dv_cnt - dv0, 0);
        run_txn("post_rst", 3, -1, ABC_D, 3);

`ifdef SHA256_HOST_CMP_EN
        exp_digest = ABC_D;
        run_txn("cmp_eq", 3, -1, ABC_D, 3);
        chk_b("cmp_match1", match, 1'b1);
        exp_digest = ABC_D ^ 256'h1;
        run_txn("cmp_ne", 3, -1, ABC_D, 3);
        chk_b("cmp_match0", match, 1'b0);
        exp_digest = ABC_D;
`endif

        // timeout on the short-timeout instance: engine never answers
        do_reset();
        tdv0 = t_dv_cnt;
        do_start();
        send_msg(3, -1, 0);
        first_to = 0;
        for (int k = 1; k <= 40; k++) begin
            tick();
            if (t_timeout_err && first_to == 0) first_to = k;
        end
        chk_n("to_latency", first_to, TO_SHORT);
        chk_b("to_idle", t_busy, 1'b0);
        chk_n("to_no_dv", t_dv_cnt - tdv0, 0);
        chk_n("to_bytes_held", int'(t_bytes_sent), 3);
        chk_b("to_main_still_busy", busy, 1'b1);
        do_reset();
        repeat (3) tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        fails++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/sha256_gpio_host.md
SHA256_GPIO_HOST -- requirements
Module: sha256_gpio_host

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 1024, max cycles allowed in COLLECT before abort.
REQ-002 Parameter LEN_W, default 16, width of the sent-byte counter.
REQ-003 clk  in  1  clock; all logic on rising edge.
REQ-004 rst  in  1  reset: rst, synchronous, active-high; clock clk.
REQ-005 start  in  1  one-cycle request to begin a hash transaction.
REQ-006 s_data  in  8, s_valid  in  1, s_last  in  1, s_ready  out  1: upstream message byte stream.
REQ-007 gpio_din  out  8, gpio_valid  out  1, gpio_last  out  1: bytes to the GPIO SHA-256 engine.
REQ-008 gpio_ready  in  1  engine can accept a byte; gpio_busy  in  1  engine busy (status only).
REQ-009 gpio_dout  in  8, gpio_dvalid  in  1: digest bytes from the engine, MSB byte first.
REQ-010 digest  out  256 captured digest; digest_valid  out  1 one-cycle completion pulse.
REQ-011 busy  out  1; timeout_err  out  1 one-cycle pulse; bytes_sent  out  LEN_W.
REQ-012 exp_digest  in  256, match  out  1: present only with SHA256_HOST_CMP_EN.

Function
REQ-013 States IDLE, SEND, COLLECT; the FSM leaves IDLE only on start.
REQ-014 IDLE: start -> SEND, bytes_sent cleared, busy=1 from the next cycle; start in SEND or COLLECT is ignored.
REQ-015 SEND: gpio_din=s_data, gpio_last=s_last, gpio_valid=s_valid, s_ready=gpio_ready, all combinational.
REQ-016 Outside SEND: gpio_valid=0 and s_ready=0.
REQ-017 A byte transfers on an edge with s_valid&&gpio_ready in SEND; bytes_sent increments and saturates at all-ones.
REQ-018 A transferred byte with s_last=1 -> COLLECT, digest byte index cleared, timeout counter cleared.
REQ-019 Every message has at least one byte; an empty message is not representable.
REQ-020 COLLECT: each gpio_dvalid shifts gpio_dout into digest LSB side (digest <= {digest[247:0], gpio_dout}); index 0..31.
REQ-021 The 32nd dvalid -> IDLE, digest_valid=1 the following cycle, busy=0, digest held stable until the next start.
REQ-022 gpio_dvalid outside COLLECT is ignored; digest is not modified.
REQ-023 The timeout counter increments each COLLECT cycle; reaching TIMEOUT_CYCLES -> IDLE, timeout_err pulses one cycle, no digest_valid.
REQ-024 On timeout, digest contents are undefined; bytes_sent holds.
REQ-025 A gpio_ready stall of any length in SEND is legal and does not time out.

Reset
REQ-026 rst: state=IDLE; busy, digest_valid, timeout_err, match=0; digest=0; bytes_sent=0; counters=0.
REQ-027 rst mid-SEND or mid-COLLECT aborts without digest_valid; the engine is reset by the system on the same rst.

Configuration
REQ-028 SHA256_HOST_CMP_EN defined: match is registered, updated with digest_valid to (digest==exp_digest), held until next start, and cleared on start.
REQ-029 SHA256_HOST_CMP_EN undefined: exp_digest/match ports and comparator are absent.

Structure
REQ-030 Package sha256_host_pkg: state enum, DIGEST_BYTES=32, DIGEST_W=256.
REQ-031 Single module; no sub-module is required.

Verification
REQ-032 start, stream "abc" (61 62 63, last on 63), engine responds -> digest=ba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad, digest_valid 1 pulse, bytes_sent=3.
REQ-033 Single byte 0x61 with last -> digest=ca978112ca1bbdcafac231b39a23dc4da786eff8147c4e72b9807785afee48bb.
REQ-034 "abc" with gpio_ready low 5 cycles before byte 2 -> no byte lost or duplicated, same digest as REQ-032.
REQ-035 TIMEOUT_CYCLES=16, engine model never emits dvalid -> timeout_err pulse 16 cycles after last, state IDLE, no digest_valid.
REQ-036 rst asserted after 10 of 32 dvalid bytes -> all outputs at reset values, next "abc" transaction correct.
REQ-037 CMP_EN, exp_digest=REQ-032 value -> match=1; exp_digest with bit 0 flipped -> match=0.
